// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-RAM arbiter.
package imem_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LD = 1'b1
  } owner_e;

  // Word-index width for a RAM of mem_size words (at least one bit).
  function automatic int unsigned calc_idx_w(int unsigned mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and RAM signals around the instruction-RAM arbiter.
// slave: arbiter side. master: requesters plus the RAM.
interface imem_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 512
);
  localparam int unsigned IDX_W = calc_idx_w(MEM_SIZE);

  // Fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;
  // Loader port
  logic                  ld_req;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_lock;
  logic                  ld_gnt;
  logic                  ld_rvalid;
  logic [DATA_WIDTH-1:0] ld_rdata;
  logic                  ld_err;
  logic                  locked;
  // RAM port
  logic                  mem_en;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output ld_gnt, ld_rvalid, ld_rdata, ld_err, locked,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  ld_gnt, ld_rvalid, ld_rdata, ld_err, locked,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_addr_check.sv
// Byte address to word index, flagging misaligned or out-of-range accesses.
module imem_addr_check #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 512,
  parameter int unsigned IDX_W      = 9
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] word;

  // Alignment and range check on the full word address.
  always_comb begin
    word = addr >> 2;
    idx  = word[IDX_W-1:0];
    err  = (addr[1:0] != 2'b00) || (word >= ADDR_WIDTH'(MEM_SIZE));
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter sharing the single synchronous-read instruction RAM port between
// the fetch stage and the loader/debug port, with an exclusive lock mode.
// Optional feature macro: IMEM_ARB_STARVE_EN (loader anti-starvation counter).
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_SIZE     = 512,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            reset,
  imem_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = calc_idx_w(MEM_SIZE);

  logic [IDX_W-1:0] if_idx, ld_idx;
  logic             if_bad, ld_bad;
  logic             if_gnt, ld_gnt;
  logic             starved;
  state_e           state_q, state_d;
  logic             rsp_rd_q, rsp_err_q;
  owner_e           rsp_owner_q;
  logic [DATA_WIDTH-1:0] rsp_data;

  imem_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .IDX_W      (IDX_W)
  ) u_if_check (
    .addr (bus.if_addr),
    .idx  (if_idx),
    .err  (if_bad)
  );

  imem_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .IDX_W      (IDX_W)
  ) u_ld_check (
    .addr (bus.ld_addr),
    .idx  (ld_idx),
    .err  (ld_bad)
  );

`ifdef IMEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = calc_idx_w(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  // Count lost arbitrations while the loader waits; any loader grant clears.
  always_comb begin
    starve_d = starve_q;
    if (ld_gnt) begin
      starve_d = '0;
    end else if (bus.ld_req && if_gnt && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict fetch priority: the loader only wins when fetch is idle.
  assign starved = 1'b0;
`endif

  // Grant decision and state transitions; grants are same-cycle combinational.
  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    ld_gnt  = 1'b0;
    unique case (state_q)
      ARB: begin
        if (bus.ld_req && (!bus.if_req || starved)) begin
          ld_gnt = 1'b1;
          if (bus.ld_lock) state_d = LOCK;
        end else if (bus.if_req) begin
          if_gnt = 1'b1;
        end
      end
      LOCK: begin
        // Unlock cycle issues no grant; arbitration resumes next cycle.
        if (!bus.ld_lock) begin
          state_d = ARB;
        end else if (bus.ld_req) begin
          ld_gnt = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM controls follow the winner; error accesses never reach the RAM.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = bus.ld_wdata;
    if (if_gnt) begin
      bus.mem_en   = !if_bad;
      bus.mem_addr = if_idx;
    end else if (ld_gnt) begin
      bus.mem_en   = !ld_bad;
      bus.mem_we   = bus.ld_we && !ld_bad;
      bus.mem_addr = ld_idx;
    end
  end

  // Response tag captured at grant: read-pending, error and owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rd_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_owner_q <= OWN_IF;
    end else begin
      rsp_rd_q    <= if_gnt || (ld_gnt && !bus.ld_we);
      rsp_err_q   <= (if_gnt && if_bad) || (ld_gnt && ld_bad);
      rsp_owner_q <= ld_gnt ? OWN_LD : OWN_IF;
    end
  end

  // Route the registered response to its owner; data is zero on error.
  always_comb begin
    rsp_data      = (rsp_rd_q && !rsp_err_q) ? bus.mem_rdata : '0;
    bus.if_gnt    = if_gnt;
    bus.ld_gnt    = ld_gnt;
    bus.locked    = (state_q == LOCK);
    bus.if_rvalid = rsp_rd_q && (rsp_owner_q == OWN_IF);
    bus.if_err    = rsp_err_q && (rsp_owner_q == OWN_IF);
    bus.if_rdata  = (rsp_owner_q == OWN_IF) ? rsp_data : '0;
    bus.ld_rvalid = rsp_rd_q && (rsp_owner_q == OWN_LD);
    bus.ld_err    = rsp_err_q && (rsp_owner_q == OWN_LD);
    bus.ld_rdata  = (rsp_owner_q == OWN_LD) ? rsp_data : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a behavioural synchronous-read RAM.
module tb_imem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MS = 512;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) bus ();

  imem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .MEM_SIZE     (MS),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] ram     [MS];
  logic [31:0] ref_mem [MS];

  // Behavioural RAM: synchronous read, write on mem_we.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    int          due;
    bit          owner;  // 0 fetch, 1 loader
    bit          rvalid;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= MS);
  endfunction

  function automatic int unsigned addr_idx(input logic [31:0] a);
    return int'((a >> 2) % MS);
  endfunction

  // One cycle of stimulus with explicit expected grants and lock state.
  task automatic step(input string tag,
                      input logic ireq, input logic [31:0] iaddr,
                      input logic lreq, input logic lwe, input logic [31:0] laddr,
                      input logic [31:0] lwdata, input logic llock,
                      input logic e_ig, input logic e_lg, input logic e_lk);
    bit ib, lb;
    logic e_en, e_we;
    @(posedge clk);
    #1;
    bus.if_req   = ireq;
    bus.if_addr  = iaddr;
    bus.ld_req   = lreq;
    bus.ld_we    = lwe;
    bus.ld_addr  = laddr;
    bus.ld_wdata = lwdata;
    bus.ld_lock  = llock;
    @(negedge clk);
    ib   = addr_bad(iaddr);
    lb   = addr_bad(laddr);
    e_en = (e_ig && !ib) || (e_lg && !lb);
    e_we = e_lg && lwe && !lb;
    check_eq({tag, " if_gnt"}, bus.if_gnt, e_ig);
    check_eq({tag, " ld_gnt"}, bus.ld_gnt, e_lg);
    check_eq({tag, " locked"}, bus.locked, e_lk);
    check_eq({tag, " mem_en"}, bus.mem_en, e_en);
    check_eq({tag, " mem_we"}, bus.mem_we, e_we);
    if (e_ig) begin
      if (!ib) check_eq({tag, " mem_addr"}, bus.mem_addr, addr_idx(iaddr));
      sb.push_back('{due: cyc + 1, owner: 1'b0, rvalid: 1'b1, err: ib,
                     data: ib ? 32'h0 : ref_mem[addr_idx(iaddr)]});
    end
    if (e_lg) begin
      if (!lb) check_eq({tag, " mem_addr"}, bus.mem_addr, addr_idx(laddr));
      if (lwe) begin
        if (lb) sb.push_back('{due: cyc + 1, owner: 1'b1, rvalid: 1'b0, err: 1'b1, data: 32'h0});
        else ref_mem[addr_idx(laddr)] = lwdata;
      end else begin
        sb.push_back('{due: cyc + 1, owner: 1'b1, rvalid: 1'b1, err: lb,
                       data: lb ? 32'h0 : ref_mem[addr_idx(laddr)]});
      end
    end
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ld_req   = 1'b0;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_wdata = '0;
    bus.ld_lock  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check_eq("rst if_gnt", bus.if_gnt, 1'b0);
    check_eq("rst ld_gnt", bus.ld_gnt, 1'b0);
    check_eq("rst locked", bus.locked, 1'b0);
    check_eq("rst mem_en", bus.mem_en, 1'b0);
    check_eq("rst mem_we", bus.mem_we, 1'b0);
    check_eq("rst if_rvalid", bus.if_rvalid, 1'b0);
    check_eq("rst ld_rvalid", bus.ld_rvalid, 1'b0);
    check_eq("rst if_err", bus.if_err, 1'b0);
    check_eq("rst ld_err", bus.ld_err, 1'b0);
    check_eq("rst if_rdata", bus.if_rdata, 32'h0);
    check_eq("rst ld_rdata", bus.ld_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Response monitor: pops responses due this cycle, else expects silence.
  always @(negedge clk) begin : mon
    rsp_t r, e_if, e_ld;
    bit hit_if, hit_ld;
    if (mon_en) begin
      hit_if = 1'b0;
      hit_ld = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        r = sb.pop_front();
        check_eq("rsp due", r.due, cyc);
        if (r.owner) begin hit_ld = 1'b1; e_ld = r; end
        else begin hit_if = 1'b1; e_if = r; end
      end
      if (hit_if) begin
        check_eq("if_rvalid", bus.if_rvalid, e_if.rvalid);
        check_eq("if_err", bus.if_err, e_if.err);
        check_eq("if_rdata", bus.if_rdata, e_if.data);
      end else begin
        check_eq("if_rvalid idle", bus.if_rvalid, 1'b0);
        check_eq("if_err idle", bus.if_err, 1'b0);
      end
      if (hit_ld) begin
        check_eq("ld_rvalid", bus.ld_rvalid, e_ld.rvalid);
        check_eq("ld_err", bus.ld_err, e_ld.err);
        check_eq("ld_rdata", bus.ld_rdata, e_ld.data);
      end else begin
        check_eq("ld_rvalid idle", bus.ld_rvalid, 1'b0);
        check_eq("ld_err idle", bus.ld_err, 1'b0);
      end
    end
  end

  initial begin
    bit el;
    for (int i = 0; i < MS; i++) begin
      ram[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    bus.mem_rdata = '0;
    idle_inputs();
    do_reset();
    mon_en = 1'b1;

    // Back-to-back fetches
    step("f0", 1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("f1", 1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0);
    step("f2", 1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0);
    // Loader read with fetch idle
    step("lrd", 0, 0, 1, 0, 32'hC, 0, 0, 0, 1, 0);
    // Address errors: misaligned fetch, out-of-range write and read
    step("ferr", 1, 32'h6, 0, 0, 0, 0, 0, 1, 0, 0);
    step("lwerr", 0, 0, 1, 1, 4 * MS, 32'hCAFEF00D, 0, 0, 1, 0);
    step("lrerr", 0, 0, 1, 0, 4 * MS, 0, 0, 0, 1, 0);
    step("fw0", 1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Lock: fetch wins while lock rises, then the loader locks
    step("lkA", 1, 32'h10, 1, 1, 32'h10, 32'hDEADBEEF, 1, 1, 0, 0);
    step("lkB", 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 1, 0, 1, 0);
    step("lkC", 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 1);
    step("lkD", 1, 32'h10, 1, 0, 32'h10, 0, 1, 0, 1, 1);
    step("lkE", 1, 32'h10, 1, 0, 32'h10, 0, 0, 0, 0, 1);
    step("lkF", 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0);

    // Reset with a fetch response in flight
    do_reset();
    step("pre0", 1, 32'h0, 1, 0, 32'h20, 0, 0, 1, 0, 0);
    step("pre1", 1, 32'h4, 1, 0, 32'h20, 0, 0, 1, 0, 0);
    step("rf", 1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0);
    void'(sb.pop_back());  // reset kills this response
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check_eq("rf if_rvalid", bus.if_rvalid, 1'b0);
    check_eq("rf locked", bus.locked, 1'b0);
    reset = 1'b0;

    // Continuous contention
    for (int k = 1; k <= 10; k++) begin
`ifdef IMEM_ARB_STARVE_EN
      el = (k % 5 == 0);
`else
      el = 1'b0;
`endif
      step($sformatf("stv%0d", k), 1, 32'(4 * k), 1, 0, 32'h20, 0, 0, !el, el, 0);
    end

    step("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("sb empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
